alu: RTL and testbench

//   Registered 4-bit-default arithmetic/logic unit: ADD, SUB, AND, OR, with NOP on unused codes.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 75 +++++++
 rtl/alu.sv | 90 +++++++++
 tb/tb_alu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_pkg                                                       |
// | Purpose  : Shared opcode encodings for the alu datapath leaf.            |
// |            OP_XOR / OP_SHL / OP_SHR are only decoded when the build      |
// |            defines ALU_EXT_OPS_EN; otherwise those codes act as NOP.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_NOP = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_core                                                      |
// | Purpose  : Purely combinational ALU function: result, carry and signed   |
// |            overflow from a, b and op_code.                               |
// |            Build option ALU_EXT_OPS_EN adds XOR / SHL / SHR.             |
// | Ports    : a, b     [WIDTH] operands (unsigned; two's complement for ovf)|
// |            op_code  [3]     operation select                             |
// |            result   [WIDTH] combinational result                         |
// |            carry            ADD carry-out / SUB no-borrow / shifted bit  |
// |            ovf              signed overflow for ADD/SUB                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op_code,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf
);

   localparam int c_msb = WIDTH - 1;

   // One extra bit on both paths: bit WIDTH of the sum is the carry-out, and
   // bit WIDTH of the difference is the borrow (set exactly when a < b).
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (op_code)
         OP_ADD: begin
            result = w_sum[WIDTH-1:0];
            carry  = w_sum[WIDTH];
            // Like-signed operands producing a result of the other sign.
            ovf    = (a[c_msb] == b[c_msb]) && (w_sum[c_msb] != a[c_msb]);
         end
         OP_SUB: begin
            result = w_diff[WIDTH-1:0];
            carry  = ~w_diff[WIDTH];
            // Opposite-signed operands where the result loses a's sign.
            ovf    = (a[c_msb] != b[c_msb]) && (w_diff[c_msb] != a[c_msb]);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
`ifdef ALU_EXT_OPS_EN
         OP_XOR: result = a ^ b;
         OP_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            carry  = a[c_msb];
         end
         OP_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            carry  = a[0];
         end
         OP_NOP: ;
`else
         OP_NOP, OP_XOR, OP_SHL, OP_SHR: ;
`endif
         default: ;
      endcase
   end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu                                                           |
// | Purpose  : Registered ALU (ADD/SUB/AND/OR, NOP on unused codes). The     |
// |            combinational alu_core result is captured with its status     |
// |            flags one clock after a valid issue. Asynchronous,            |
// |            active-high reset.                                            |
// |            Build option ALU_EXT_OPS_EN enables XOR / SHL / SHR.          |
// | Ports    : clk, rst          clock, async active-high reset              |
// |            in_valid          operands/opcode valid this cycle            |
// |            a, b     [WIDTH]  operands                                    |
// |            op_code  [3]      operation select                            |
// |            result   [WIDTH]  registered result                           |
// |            out_valid         result/flags updated from a valid op        |
// |            carry, zero, negative, ovf   registered status flags          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op_code,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             ovf
);

   logic [WIDTH-1:0] w_core_result;
   logic             w_core_carry;
   logic             w_core_ovf;

   logic [WIDTH-1:0] r_result;
   logic             r_out_valid;
   logic             r_carry;
   logic             r_zero;
   logic             r_negative;
   logic             r_ovf;

   alu_core #(
      .WIDTH   (WIDTH)
   ) u_core (
      .a       (a),
      .b       (b),
      .op_code (op_code),
      .result  (w_core_result),
      .carry   (w_core_carry),
      .ovf     (w_core_ovf)
   );

   // out_valid follows in_valid every cycle; the result and flags only load
   // on a valid issue so they hold across idle cycles. zero resets high to
   // stay consistent with the cleared result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b1;
         r_negative  <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_result   <= w_core_result;
            r_carry    <= w_core_carry;
            r_zero     <= (w_core_result == '0);
            r_negative <= w_core_result[WIDTH-1];
            r_ovf      <= w_core_ovf;
         end
      end
   end

   assign result    = r_result;
   assign out_valid = r_out_valid;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign negative  = r_negative;
   assign ovf       = r_ovf;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu                                                        |
// | Purpose  : Self-checking bench for alu (WIDTH=4). Expected outputs come  |
// |            from an integer reference model and are queued at issue time, |
// |            then popped and compared one cycle later. Extended-op vectors |
// |            are included when ALU_EXT_OPS_EN is defined.                  |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu;
   import alu_pkg::*;

   localparam int W    = 4;
   localparam int MOD  = 1 << W;
   localparam int HALF = MOD / 2;

   typedef struct packed {
      logic [W-1:0] result;
      logic         carry;
      logic         ovf;
      logic         zero;
      logic         negative;
      logic         out_valid;
   } exp_t;

   localparam exp_t RESET_EXP = '{result: '0, carry: 1'b0, ovf: 1'b0,
                                  zero: 1'b1, negative: 1'b0, out_valid: 1'b0};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op_code = 3'b000;
   logic [W-1:0] result;
   logic         out_valid;
   logic         carry;
   logic         zero;
   logic         negative;
   logic         ovf;

   exp_t q[$];
   exp_t mstate;
   int   n_vec = 0;
   int   n_err = 0;

   alu #(
      .WIDTH     (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .op_code   (op_code),
      .result    (result),
      .out_valid (out_valid),
      .carry     (carry),
      .zero      (zero),
      .negative  (negative),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, ".result"},    result,         e.result);
      check({tag, ".carry"},     W'(carry),      W'(e.carry));
      check({tag, ".ovf"},       W'(ovf),        W'(e.ovf));
      check({tag, ".zero"},      W'(zero),       W'(e.zero));
      check({tag, ".negative"},  W'(negative),   W'(e.negative));
      check({tag, ".out_valid"}, W'(out_valid),  W'(e.out_valid));
   endtask

   function automatic int sgn(input int v);
      return (v >= HALF) ? v - MOD : v;
   endfunction

   // Integer reference: arithmetic done on unbounded ints, then reduced.
   function automatic exp_t model(input logic v, input logic [W-1:0] a_i,
                                  input logic [W-1:0] b_i, input logic [2:0] op,
                                  input exp_t prev);
      exp_t e;
      int   ia, ib, r, ss;
      logic c, o;
      e  = prev;
      if (!v) begin
         e.out_valid = 1'b0;
         return e;
      end
      ia = int'(a_i);
      ib = int'(b_i);
      r  = 0;
      c  = 1'b0;
      o  = 1'b0;
      case (op)
         3'd0: begin
            r  = (ia + ib) % MOD;
            c  = (ia + ib) >= MOD;
            ss = sgn(ia) + sgn(ib);
            o  = (ss > HALF - 1) || (ss < -HALF);
         end
         3'd1: begin
            r  = (ia - ib + MOD) % MOD;
            c  = (ia >= ib);
            ss = sgn(ia) - sgn(ib);
            o  = (ss > HALF - 1) || (ss < -HALF);
         end
         3'd2: r = int'(a_i & b_i);
         3'd3: r = int'(a_i | b_i);
`ifdef ALU_EXT_OPS_EN
         3'd5: r = int'(a_i ^ b_i);
         3'd6: begin
            r = (ia * 2) % MOD;
            c = (ia >= HALF);
         end
         3'd7: begin
            r = ia / 2;
            c = (ia % 2) == 1;
         end
`endif
         default: r = 0;
      endcase
      e.result    = r[W-1:0];
      e.carry     = c;
      e.ovf       = o;
      e.zero      = (r == 0);
      e.negative  = (r >= HALF);
      e.out_valid = 1'b1;
      return e;
   endfunction

   // Each step checks the previously queued op, then issues a new one.
   task automatic step(input logic v, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       input logic [2:0] op);
      @(negedge clk);
      if (q.size() > 0) check_outputs("op", q.pop_front());
      in_valid = v;
      a        = a_i;
      b        = b_i;
      op_code  = op;
      mstate   = model(v, a_i, b_i, op, mstate);
      q.push_back(mstate);
   endtask

   task automatic flush();
      @(negedge clk);
      if (q.size() > 0) check_outputs("op", q.pop_front());
      in_valid = 1'b0;
   endtask

   initial begin
      // Asynchronous reset, checked before any clock edge.
      #2 rst = 1'b1;
      #1 check_outputs("reset", RESET_EXP);
      mstate = RESET_EXP;
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors.
      step(1'b1, 4'b0011, 4'b0101, OP_ADD);
      step(1'b1, 4'b0011, 4'b0101, OP_SUB);
      step(1'b1, 4'b0011, 4'b0101, OP_AND);
      step(1'b1, 4'b0011, 4'b0101, OP_OR);
      step(1'b1, 4'b0011, 4'b0101, OP_NOP);
      step(1'b1, 4'b1111, 4'b0001, OP_ADD);
      step(1'b1, 4'b0111, 4'b1000, OP_SUB);
      step(1'b1, 4'b0101, 4'b0101, OP_SUB);

      // Hold across idle cycles.
      step(1'b1, 4'b0011, 4'b0101, OP_ADD);
      step(1'b0, 4'b1111, 4'b1111, OP_OR);
      step(1'b0, 4'b0000, 4'b0000, OP_ADD);
      step(1'b0, 4'b1010, 4'b0101, OP_SUB);
      flush();

      // Mid-stream reset with an op in flight.
      step(1'b1, 4'b0011, 4'b0101, OP_ADD);
      flush();
      in_valid = 1'b1;
      a        = 4'b0111;
      b        = 4'b0111;
      op_code  = OP_ADD;
      #2 rst = 1'b1;
      #1 check_outputs("async_rst", RESET_EXP);
      @(posedge clk);
      #1 check_outputs("rst_discard", RESET_EXP);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      mstate   = RESET_EXP;
      step(1'b1, 4'b0111, 4'b0001, OP_ADD);
      step(1'b1, 4'b1000, 4'b0001, OP_SUB);

`ifdef ALU_EXT_OPS_EN
      step(1'b1, 4'b1001, 4'b0000, OP_SHL);
      step(1'b1, 4'b1001, 4'b0000, OP_SHR);
      step(1'b1, 4'b0011, 4'b0101, OP_XOR);
      step(1'b1, 4'b0110, 4'b0000, OP_SHR);
      step(1'b1, 4'b0110, 4'b0000, OP_NOP);
`else
      step(1'b1, 4'b1001, 4'b0110, OP_XOR);
      step(1'b1, 4'b1001, 4'b0110, OP_SHL);
      step(1'b1, 4'b1001, 4'b0110, OP_SHR);
`endif

      // Random back-to-back traffic with occasional idle cycles.
      for (int i = 0; i < 40; i++) begin
         step(($urandom_range(0, 4) != 0), W'($urandom_range(0, MOD - 1)),
              W'($urandom_range(0, MOD - 1)), 3'($urandom_range(0, 7)));
      end
      flush();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_alu
`default_nettype wire
